// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the FP32 divider arbiter and its helpers.
package fpdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND,
        FLUSH
    } arb_state_t;

    localparam logic [31:0] FP32_QNAN      = 32'h7FC0_0000;
    localparam int          DIV_RST_CYCLES = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, searched circularly.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   ptr,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [IDX_W-1:0]   ptr_next
);

    int cand;

    // NOTE: combinational logic uses blocking assignments, and every output gets a default first so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!grant_valid && req_valid[IDX_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
        ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end

endmodule

// File: rtl/fpdiv_arbiter.sv
// Shares one multi-cycle FP32 divider among NUM_REQ requesters with round-robin
// arbitration, a fully registered sequencer, and a hung-divider watchdog.
module fpdiv_arbiter
    import fpdiv_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0][31:0] req_a,
    input  logic [NUM_REQ-1:0][31:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [31:0]              rsp_result,
    output logic                     rsp_nan,
    output logic                     rsp_timeout,
    output logic [31:0]              div_a,
    output logic [31:0]              div_b,
    output logic                     div_en,
    output logic                     div_rst,
    input  logic [31:0]              div_result,
    input  logic                     div_ready,
    input  logic                     div_nan,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     ptr, ptr_nxt, gidx, gidx_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
    logic [31:0]          div_a_nxt, div_b_nxt, rsp_result_nxt;
    logic [NUM_REQ-1:0]   req_ready_nxt, rsp_valid_nxt;
    logic                 div_en_nxt, div_rst_nxt, rsp_nan_nxt, rsp_timeout_nxt, busy_nxt;
    logic                 arb_valid;
    logic [IDX_W-1:0]     arb_idx, arb_ptr_next;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req_valid   (req_valid),
        .ptr         (ptr),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx),
        .ptr_next    (arb_ptr_next)
    );

    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        gidx_nxt        = gidx;
        cnt_nxt         = cnt;
        div_a_nxt       = div_a;
        div_b_nxt       = div_b;
        div_en_nxt      = 1'b0;
        div_rst_nxt     = div_rst;
        req_ready_nxt   = '0;
        rsp_valid_nxt   = rsp_valid;
        rsp_result_nxt  = rsp_result;
        rsp_nan_nxt     = rsp_nan;
        rsp_timeout_nxt = rsp_timeout;

        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    gidx_nxt               = arb_idx;
                    ptr_nxt                = arb_ptr_next;
                    div_a_nxt              = req_a[arb_idx];
                    div_b_nxt              = req_b[arb_idx];
                    req_ready_nxt[arb_idx] = 1'b1;
                    div_en_nxt             = 1'b1;
                    state_nxt              = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                // A completion in the watchdog's final cycle still counts as a normal result.
                if (div_ready || div_nan) begin
                    rsp_result_nxt      = div_result;
                    rsp_nan_nxt         = div_nan;
                    rsp_valid_nxt[gidx] = 1'b1;
                    state_nxt           = RESPOND;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    rsp_result_nxt  = FP32_QNAN;
                    rsp_nan_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    div_rst_nxt     = 1'b1;
                    cnt_nxt         = '0;
                    state_nxt       = FLUSH;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            FLUSH: begin
                if (cnt == CNT_W'(DIV_RST_CYCLES - 1)) begin
                    div_rst_nxt         = 1'b0;
                    rsp_valid_nxt[gidx] = 1'b1;
                    state_nxt           = RESPOND;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            RESPOND: begin
                if (rsp_ready[gidx]) begin
                    rsp_valid_nxt   = '0;
                    rsp_nan_nxt     = 1'b0;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx        <= '0;
            cnt         <= '0;
            div_a       <= '0;
            div_b       <= '0;
            div_en      <= 1'b0;
            div_rst     <= 1'b0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_result  <= '0;
            rsp_nan     <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gidx        <= gidx_nxt;
            cnt         <= cnt_nxt;
            div_a       <= div_a_nxt;
            div_b       <= div_b_nxt;
            div_en      <= div_en_nxt;
            div_rst     <= div_rst_nxt;
            req_ready   <= req_ready_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_result  <= rsp_result_nxt;
            rsp_nan     <= rsp_nan_nxt;
            rsp_timeout <= rsp_timeout_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_fpdiv_arbiter.sv
// Self-checking bench for fpdiv_arbiter: a behavioural divider stand-in plus a
// round-robin reference model, driven by directed and randomized scenarios.
`timescale 1ns/1ps
module tb_fpdiv_arbiter;
    import fpdiv_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 63;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NUM_REQ-1:0][31:0] req_a, req_b;
    logic [31:0]              rsp_result, div_a, div_b, div_result;
    logic                     rsp_nan, rsp_timeout, div_en, div_rst, div_ready, div_nan, busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_ptr  = 0;
    bit hang     = 1'b0;
    int dlat     = 4;

    int o_grant, o_grants, o_ens, o_rsts, o_lat;
    bit o_got;

    fpdiv_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_nan(rsp_nan), .rsp_timeout(rsp_timeout),
        .div_a(div_a), .div_b(div_b), .div_en(div_en), .div_rst(div_rst),
        .div_result(div_result), .div_ready(div_ready), .div_nan(div_nan), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in quotient: the one exact case the plan names, NaN for 0/0, otherwise an operand tag.
    function automatic logic [31:0] quot_ref(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4080_0000 && b == 32'h4000_0000) return 32'h4000_0000;
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return FP32_QNAN;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic bit is_nan_op(input logic [31:0] a, input logic [31:0] b);
        return (a[30:0] == 31'd0 && b[30:0] == 31'd0);
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++)
            if (mask[(exp_ptr + i) % NUM_REQ]) return (exp_ptr + i) % NUM_REQ;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Divider model: latches operands on En, completes after dlat cycles unless hung or reset.
    initial begin
        int left;
        bit active;
        logic [31:0] ma, mb;
        div_ready = 1'b0; div_nan = 1'b0; div_result = '0;
        active = 1'b0; left = 0; ma = '0; mb = '0;
        forever begin
            @(negedge clk);
            div_ready  = 1'b0;
            div_nan    = 1'b0;
            div_result = $urandom;
            if (reset || div_rst) begin
                active = 1'b0;
            end else if (div_en) begin
                active = 1'b1; left = dlat; ma = div_a; mb = div_b;
            end else if (active && !hang) begin
                left--;
                if (left <= 0) begin
                    active     = 1'b0;
                    div_result = quot_ref(ma, mb);
                    if (is_nan_op(ma, mb)) div_nan = 1'b1;
                    else div_ready = 1'b1;
                end
            end
        end
    end

    task automatic observe_op(input string name, input bit drop, input int budget);
        int en_cyc;
        en_cyc = 0;
        o_grant = -1; o_grants = 0; o_ens = 0; o_rsts = 0; o_lat = -1; o_got = 1'b0;
        for (int c = 0; c < budget && !o_got; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                o_grants++;
                o_grant = onehot_idx(req_ready);
                if (drop && o_grant >= 0) req_valid[o_grant] = 1'b0;
            end
            if (div_en) begin o_ens++; en_cyc = c; end
            if (div_rst) o_rsts++;
            if (rsp_valid != '0) begin o_got = 1'b1; o_lat = c - en_cyc; end
        end
        n_checks++;
        if (!o_got) begin n_errors++; $display("FAIL %s_no_response: no rsp_valid within %0d cycles", name, budget); end
    endtask

    task automatic finish_rsp(input string name);
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, rsp_nan, rsp_timeout} !== '0) begin
            n_errors++;
            $display("FAIL %s_handshake: rsp_valid=%b nan=%b timeout=%b, required all 0", name, rsp_valid, rsp_nan, rsp_timeout);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_result, rsp_nan, rsp_timeout, div_a, div_b, div_en, div_rst, busy} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b div_en=%b busy=%b, required all 0", req_ready, rsp_valid, div_en, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_ptr = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, req_ready, div_en} !== '0) begin
            n_errors++; $display("FAIL reset_idle: busy=%b req_ready=%b div_en=%b, required 0", busy, req_ready, div_en);
        end
    endtask

    task automatic test_single;
        hang = 1'b0; dlat = 5; rsp_ready = '1;
        req_a[0] = 32'h4080_0000; req_b[0] = 32'h4000_0000;
        req_valid = 4'b0001;
        observe_op("single", 1'b1, 100);
        n_checks++;
        if (o_grant !== 0) begin n_errors++; $display("FAIL single_grant: got %0d, required 0", o_grant); end
        n_checks++;
        if (o_grants !== 1 || o_ens !== 1) begin
            n_errors++; $display("FAIL single_pulses: req_ready cycles %0d div_en cycles %0d, required 1 and 1", o_grants, o_ens);
        end
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 32'h4000_0000 || rsp_nan !== 1'b0) begin
            n_errors++; $display("FAIL single_rsp: valid=%b result=%h nan=%b, required 0001 40000000 0", rsp_valid, rsp_result, rsp_nan);
        end
        n_checks++;
        if (o_lat !== dlat + 1) begin n_errors++; $display("FAIL single_latency: got %0d, required %0d", o_lat, dlat + 1); end
        exp_ptr = 1;
        finish_rsp("single");
    endtask

    task automatic test_round_robin;
        int g_exp;
        test_reset();
        dlat = 3; rsp_ready = '1;
        for (int i = 0; i < NUM_REQ; i++) begin req_a[i] = $urandom; req_b[i] = $urandom | 32'h1; end
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            g_exp = rr_pick(req_valid);
            observe_op("rr", 1'b0, 100);
            n_checks++;
            if (o_grant !== g_exp || onehot_idx(rsp_valid) !== g_exp) begin
                n_errors++; $display("FAIL rr_order[%0d]: grant %0d rsp_valid %b, required index %0d", k, o_grant, rsp_valid, g_exp);
            end
            n_checks++;
            if (rsp_result !== quot_ref(req_a[g_exp], req_b[g_exp])) begin
                n_errors++; $display("FAIL rr_result[%0d]: got %h, required %h", k, rsp_result, quot_ref(req_a[g_exp], req_b[g_exp]));
            end
            exp_ptr = (g_exp + 1) % NUM_REQ;
            finish_rsp("rr");
        end
        req_valid = '0;
    endtask

    task automatic test_nan;
        dlat = 6; rsp_ready = '1;
        req_a[2] = 32'h0; req_b[2] = 32'h0;
        req_valid = 4'b0100;
        observe_op("nan", 1'b1, 100);
        n_checks++;
        if (rsp_valid !== 4'b0100 || rsp_nan !== 1'b1 || rsp_result !== FP32_QNAN || rsp_timeout !== 1'b0) begin
            n_errors++;
            $display("FAIL nan_rsp: valid=%b nan=%b result=%h timeout=%b, required 0100 1 7fc00000 0", rsp_valid, rsp_nan, rsp_result, rsp_timeout);
        end
        exp_ptr = 3;
        finish_rsp("nan");
    endtask

    task automatic test_watchdog;
        int r, g_exp;
        hang = 1'b1; rsp_ready = '1;
        r = $urandom_range(0, NUM_REQ - 1);
        req_a[r] = $urandom | 32'h1; req_b[r] = $urandom | 32'h1;
        req_valid = '0; req_valid[r] = 1'b1;
        g_exp = rr_pick(req_valid);
        observe_op("watchdog", 1'b1, 200);
        n_checks++;
        if (o_grant !== g_exp || onehot_idx(rsp_valid) !== g_exp) begin
            n_errors++; $display("FAIL watchdog_index: grant %0d rsp_valid %b, required %0d", o_grant, rsp_valid, g_exp);
        end
        n_checks++;
        if (o_rsts !== 2) begin n_errors++; $display("FAIL watchdog_div_rst: high %0d cycles, required 2", o_rsts); end
        n_checks++;
        if (rsp_timeout !== 1'b1 || rsp_nan !== 1'b1 || rsp_result !== FP32_QNAN) begin
            n_errors++; $display("FAIL watchdog_rsp: timeout=%b nan=%b result=%h, required 1 1 7fc00000", rsp_timeout, rsp_nan, rsp_result);
        end
        n_checks++;
        if (o_lat !== TIMEOUT + 3) begin n_errors++; $display("FAIL watchdog_latency: got %0d, required %0d", o_lat, TIMEOUT + 3); end
        exp_ptr = (g_exp + 1) % NUM_REQ;
        finish_rsp("watchdog");
        hang = 1'b0;
    endtask

    task automatic test_timeout_boundary;
        int g_exp;
        bit to_exp;
        rsp_ready = '1; hang = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dlat   = TIMEOUT + k;
            to_exp = (k == 1);
            req_a[1] = $urandom | 32'h1; req_b[1] = $urandom | 32'h1;
            req_valid = 4'b0010;
            g_exp = rr_pick(req_valid);
            observe_op("boundary", 1'b1, 200);
            n_checks++;
            if (rsp_timeout !== to_exp || o_rsts !== (to_exp ? 2 : 0)) begin
                n_errors++; $display("FAIL boundary_timeout[lat %0d]: timeout=%b div_rst cycles %0d, required %b", dlat, rsp_timeout, o_rsts, to_exp);
            end
            n_checks++;
            if (rsp_result !== (to_exp ? FP32_QNAN : quot_ref(req_a[1], req_b[1])) || rsp_nan !== to_exp) begin
                n_errors++; $display("FAIL boundary_result[lat %0d]: result=%h nan=%b", dlat, rsp_result, rsp_nan);
            end
            n_checks++;
            if (o_lat !== (to_exp ? TIMEOUT + 3 : TIMEOUT + 1)) begin
                n_errors++; $display("FAIL boundary_latency[lat %0d]: got %0d", dlat, o_lat);
            end
            exp_ptr = (g_exp + 1) % NUM_REQ;
            finish_rsp("boundary");
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        bit stable, quiet;
        int g_exp;
        dlat = 3; rsp_ready = '0;
        req_a[1] = $urandom | 32'h1; req_b[1] = $urandom | 32'h1;
        req_a[3] = $urandom | 32'h1; req_b[3] = $urandom | 32'h1;
        req_valid = 4'b0010;
        g_exp = rr_pick(req_valid);
        observe_op("backpressure", 1'b1, 100);
        exp_ptr = (g_exp + 1) % NUM_REQ;
        held = rsp_result;
        req_valid = 4'b1000;
        stable = 1'b1; quiet = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0010 || rsp_result !== held) stable = 1'b0;
            if (div_en !== 1'b0 || req_ready !== '0) quiet = 1'b0;
        end
        n_checks++;
        if (!stable || held !== quot_ref(req_a[1], req_b[1])) begin
            n_errors++; $display("FAIL backpressure_hold: rsp_valid=%b result=%h, required 0010 %h held", rsp_valid, rsp_result, quot_ref(req_a[1], req_b[1]));
        end
        n_checks++;
        if (!quiet) begin n_errors++; $display("FAIL backpressure_no_issue: grant or div_en seen while response pending"); end
        rsp_ready = 4'b0010;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== '0) begin n_errors++; $display("FAIL backpressure_release: rsp_valid=%b, required 0000", rsp_valid); end
        rsp_ready = '1;
        g_exp = rr_pick(req_valid);
        observe_op("backpressure_next", 1'b1, 100);
        n_checks++;
        if (o_grant !== g_exp || rsp_result !== quot_ref(req_a[3], req_b[3])) begin
            n_errors++; $display("FAIL backpressure_next: grant %0d result %h, required %0d %h", o_grant, rsp_result, g_exp, quot_ref(req_a[3], req_b[3]));
        end
        exp_ptr = (g_exp + 1) % NUM_REQ;
        finish_rsp("backpressure_next");
    endtask

    task automatic test_random;
        int g_exp;
        bit drop;
        rsp_ready = '1; hang = 1'b0;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin req_a[i] = $urandom | 32'h1; req_b[i] = $urandom; end
            dlat = $urandom_range(1, 8);
            drop = 1'($urandom_range(0, 1));
            req_valid = 4'($urandom_range(1, 15));
            g_exp = rr_pick(req_valid);
            observe_op("random", drop, 100);
            n_checks++;
            if (o_grant !== g_exp || onehot_idx(rsp_valid) !== g_exp) begin
                n_errors++; $display("FAIL random_index[%0d]: grant %0d rsp_valid %b, required %0d", k, o_grant, rsp_valid, g_exp);
            end
            n_checks++;
            if (rsp_result !== quot_ref(req_a[g_exp], req_b[g_exp]) || rsp_nan !== 1'b0 || o_lat !== dlat + 1) begin
                n_errors++; $display("FAIL random_rsp[%0d]: result %h nan %b latency %0d, required %h 0 %0d", k, rsp_result, rsp_nan, o_lat, quot_ref(req_a[g_exp], req_b[g_exp]), dlat + 1);
            end
            exp_ptr = (g_exp + 1) % NUM_REQ;
            finish_rsp("random");
            req_valid = '0;
        end
    endtask

    task automatic test_reset_mid_wait;
        bit seen;
        hang = 1'b1; rsp_ready = '1;
        req_a[2] = $urandom | 32'h1; req_b[2] = $urandom | 32'h1;
        req_valid = 4'b0100;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (req_ready != '0) req_valid = '0;
            if (div_en) seen = 1'b1;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (!seen || busy !== 1'b1) begin n_errors++; $display("FAIL midreset_setup: div_en seen %b busy %b, required 1 1", seen, busy); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_result, rsp_nan, rsp_timeout, div_a, div_b, div_en, div_rst, busy} !== '0) begin
            n_errors++; $display("FAIL midreset_outputs: div_a=%h busy=%b div_en=%b, required all 0", div_a, busy, div_en);
        end
        @(negedge clk);
        reset = 1'b0;
        hang = 1'b0; dlat = 2;
        exp_ptr = 0;
        for (int i = 0; i < NUM_REQ; i++) begin req_a[i] = $urandom | 32'h1; req_b[i] = $urandom; end
        req_valid = '1;
        observe_op("midreset_after", 1'b1, 100);
        n_checks++;
        if (o_grant !== rr_pick(4'b1111) || rsp_result !== quot_ref(req_a[0], req_b[0])) begin
            n_errors++; $display("FAIL midreset_first_grant: grant %0d result %h, required 0 %h", o_grant, rsp_result, quot_ref(req_a[0], req_b[0]));
        end
        finish_rsp("midreset_after");
        req_valid = '0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; rsp_ready = '1;
        req_a = '0; req_b = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_nan();
        test_watchdog();
        test_timeout_boundary();
        test_backpressure();
        test_random();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
